// File: rtl/key_seq_pkg.sv
// Shared types and helpers for the bus key sequencer: FSM state encoding,
// key-step extraction and the Galois LFSR next-state rule.
package key_seq_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } seq_state_t;

  // Generous fixed widths so the helpers serve any legal parameter set;
  // callers size-cast arguments up and results back down.
  localparam int unsigned KEY_MAX_BITS = 256;
  localparam int unsigned STEP_MAX_W   = 32;
  localparam int unsigned LFSR_MAX_W   = 64;

  function automatic logic [STEP_MAX_W-1:0] key_step(
    input logic [KEY_MAX_BITS-1:0] key,
    input int unsigned             i,
    input int unsigned             w
  );
    logic [KEY_MAX_BITS-1:0] sh;
    logic [STEP_MAX_W-1:0]   mask;
    sh   = key >> (i * w);
    mask = (w >= STEP_MAX_W) ? '1 : ((STEP_MAX_W'(1) << w) - STEP_MAX_W'(1));
    return sh[STEP_MAX_W-1:0] & mask;
  endfunction

  // Right-shifting Galois form: the bit shifted out selects the tap feedback.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/resp_lfsr.sv
// Response bit generator: Galois LFSR that advances on step and returns to
// its seed on reload (reload wins when both are asserted).
module resp_lfsr
  import key_seq_pkg::*;
#(
  parameter int              W    = 16,
  parameter logic [W-1:0]    TAPS = 16'hB400,
  parameter logic [W-1:0]    SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         reload,
  output logic [W-1:0] lfsr
);

  logic [W-1:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else if (reload) begin
      lfsr_reg <= SEED;
    end else if (step) begin
      lfsr_reg <= W'(lfsr_next(LFSR_MAX_W'(lfsr_reg), LFSR_MAX_W'(TAPS)));
    end
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/bus_key_sequencer.sv
// Bus-snooping key engine: a programmed sequence of address-field reads
// unlocks a data port that streams LFSR response bits; repeated misses lock out.
module bus_key_sequencer
  import key_seq_pkg::*;
#(
  parameter int                       ADDR_W      = 14,
  parameter logic [ADDR_W-1:0]        WIN_MASK    = 14'h3000,
  parameter logic [ADDR_W-1:0]        WIN_MATCH   = 14'h1000,
  parameter int                       PORT_BIT    = 8,
  parameter int                       KEY_LO      = 4,
  parameter int                       KEY_W       = 4,
  parameter int                       KEY_LEN     = 4,
  parameter logic [KEY_LEN*KEY_W-1:0] KEY         = 16'hC9A5,
  parameter int                       LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]        LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0]        LFSR_SEED   = 16'hACE1,
  parameter int                       MAX_FAIL    = 3,
  parameter int                       LOCKOUT_CYC = 1024,
  parameter int                       RESP_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bus_valid,
  input  logic                             sser_n,
  input  logic                             br_w,
  input  logic [ADDR_W-1:0]                ba,
  output logic                             sdrd,
  output logic                             sdrd_oe,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic [$clog2(KEY_LEN+1)-1:0]     stage,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int STAGE_W = $clog2(KEY_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int TMR_W   = $clog2(LOCKOUT_CYC);
  localparam int TAB_N   = 1 << STAGE_W;

  seq_state_t           state_reg, state_next;
  logic [STAGE_W-1:0]   stage_reg, stage_next;
  logic [FAIL_W-1:0]    fail_reg, fail_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic                 sdrd_reg, sdrd_next;
  logic                 oe_reg, oe_next;
  logic                 lfsr_step, lfsr_reload;
  logic [LFSR_W-1:0]    lfsr_state;

  logic                 acc, key_acc, dat_acc;
  logic [KEY_W-1:0]     field;
  logic [STAGE_W-1:0]   eval_idx;
  logic                 hit, first_hit, fail_trip, mode_bit;

  // Padded step table so any stage encoding indexes a defined entry.
  logic [KEY_W-1:0] step_tab [TAB_N];

  for (genvar gi = 0; gi < TAB_N; gi++) begin : g_step
    if (gi < KEY_LEN) begin : g_key
      assign step_tab[gi] = KEY_W'(key_step(KEY_MAX_BITS'(KEY), gi, KEY_W));
    end else begin : g_pad
      assign step_tab[gi] = '0;
    end
  end

  assign acc     = bus_valid & ~sser_n & br_w & ((ba & WIN_MASK) == WIN_MATCH);
  assign key_acc = acc & ~ba[PORT_BIT];
  assign dat_acc = acc & ba[PORT_BIT];
  assign field   = ba[KEY_LO +: KEY_W];

  // A key read while open restarts the attempt, so it is judged as step 0.
  assign eval_idx  = (state_reg == OPEN) ? '0 : stage_reg;
  assign hit       = (field == step_tab[eval_idx]);
  assign first_hit = (field == step_tab[0]);
  assign fail_trip = ((fail_reg + FAIL_W'(1)) == FAIL_W'(MAX_FAIL));
  assign mode_bit  = (RESP_MODE == 1) ? ^field : 1'b0;

  resp_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_resp_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (lfsr_step),
    .reload (lfsr_reload),
    .lfsr   (lfsr_state)
  );

  always_comb begin
    state_next  = state_reg;
    stage_next  = stage_reg;
    fail_next   = fail_reg;
    timer_next  = timer_reg;
    sdrd_next   = 1'b0;
    oe_next     = dat_acc;
    lfsr_step   = 1'b0;
    lfsr_reload = 1'b0;

    case (state_reg)
      LOCKOUT: begin
        if (dat_acc) sdrd_next = ^stage_reg;
        if (timer_reg == '0) begin
          state_next = SEEK;
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      default: begin
        if (dat_acc) begin
          if (state_reg == OPEN) begin
            sdrd_next = lfsr_state[0] ^ mode_bit;
            lfsr_step = 1'b1;
          end else begin
            sdrd_next = ^stage_reg;
          end
        end
        if (key_acc) begin
          state_next  = SEEK;
          lfsr_reload = (state_reg == OPEN);
          if (hit) begin
            if (eval_idx == STAGE_W'(KEY_LEN - 1)) begin
              state_next = OPEN;
              stage_next = STAGE_W'(KEY_LEN);
              fail_next  = '0;
            end else begin
              stage_next = eval_idx + STAGE_W'(1);
            end
          end else if (fail_trip) begin
            state_next = LOCKOUT;
            timer_next = TMR_W'(LOCKOUT_CYC - 1);
            stage_next = '0;
            fail_next  = '0;
          end else begin
            stage_next = first_hit ? STAGE_W'(1) : '0;
            fail_next  = fail_reg + FAIL_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SEEK;
      stage_reg <= '0;
      fail_reg  <= '0;
      timer_reg <= '0;
      sdrd_reg  <= 1'b0;
      oe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      fail_reg  <= fail_next;
      timer_reg <= timer_next;
      sdrd_reg  <= sdrd_next;
      oe_reg    <= oe_next;
    end
  end

  // A zero state would freeze the response stream permanently.
  assert property (@(posedge clk) disable iff (rst) lfsr_state != '0);

  assign sdrd       = sdrd_reg;
  assign sdrd_oe    = oe_reg;
  assign unlocked   = (state_reg == OPEN);
  assign locked_out = (state_reg == LOCKOUT);
  assign stage      = stage_reg;
  assign fail_cnt   = fail_reg;

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Self-checking bench for bus_key_sequencer: directed vector table, lockout and
// reset sequences, then randomized traffic against a behavioural model.
module tb_bus_key_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        sser_n = 1'b1;
  logic        br_w = 1'b0;
  logic [13:0] ba = '0;
  logic        sdrd, sdrd_oe, unlocked, locked_out;
  logic [2:0]  stage;
  logic [1:0]  fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bus_key_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus_valid  (bus_valid),
    .sser_n     (sser_n),
    .br_w       (br_w),
    .ba         (ba),
    .sdrd       (sdrd),
    .sdrd_oe    (sdrd_oe),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .stage      (stage),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int key_steps [4] = '{5, 10, 9, 12};   // nibbles of 0xC9A5, LSB first
  int m_stage, m_fail, m_timer, m_nread;
  bit m_open, m_lock, exp_sdrd, exp_oe;

  function automatic bit lfsr_bit(int n);
    int s = 16'hACE1;
    for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s[0];
  endfunction

  task automatic model_reset();
    m_stage = 0; m_fail = 0; m_timer = 0; m_nread = 0;
    m_open = 0; m_lock = 0; exp_sdrd = 0; exp_oe = 0;
  endtask

  task automatic model_attempt(int f);
    if (f == key_steps[m_stage]) begin
      m_stage++;
      if (m_stage == 4) begin m_open = 1; m_fail = 0; end
    end else begin
      m_fail++;
      if (m_fail == 3) begin
        m_lock = 1; m_timer = 1023; m_fail = 0; m_stage = 0;
      end else begin
        m_stage = (f == key_steps[0]) ? 1 : 0;
      end
    end
  endtask

  task automatic model_cycle(bit acc, bit port, int f);
    exp_oe = acc && port;
    exp_sdrd = 0;
    if (m_lock) begin
      if (acc && port) exp_sdrd = $countones(m_stage) % 2;
      if (m_timer == 0) m_lock = 0; else m_timer--;
    end else if (m_open) begin
      if (acc && port) begin
        exp_sdrd = lfsr_bit(m_nread);
        m_nread++;
      end else if (acc) begin
        m_open = 0; m_nread = 0; m_stage = 0;
        model_attempt(f);
      end
    end else begin
      if (acc && port) exp_sdrd = $countones(m_stage) % 2;
      else if (acc) model_attempt(f);
    end
  endtask

  // ---------------- stimulus / checking helpers ----------------
  task automatic bus_cycle(bit v, bit sn, bit rw, logic [13:0] a);
    @(negedge clk);
    bus_valid = v; sser_n = sn; br_w = rw; ba = a;
    model_cycle(v && !sn && rw && ((a & 14'h3000) == 14'h1000), a[8], int'(a[7:4]));
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int e_stage, int e_fail, bit e_unl, bit e_lock,
                       bit e_sdrd, bit e_oe);
    n_checks++;
    if ({stage, fail_cnt, unlocked, locked_out, sdrd, sdrd_oe} !==
        {3'(e_stage), 2'(e_fail), e_unl, e_lock, e_sdrd, e_oe}) begin
      n_errors++;
      $display("FAIL %s: got stage=%0d fail=%0d unl=%0b lock=%0b sdrd=%0b oe=%0b, expected stage=%0d fail=%0d unl=%0b lock=%0b sdrd=%0b oe=%0b",
               name, stage, fail_cnt, unlocked, locked_out, sdrd, sdrd_oe,
               e_stage, e_fail, e_unl, e_lock, e_sdrd, e_oe);
    end
  endtask

  task automatic check_model(string name);
    check(name, m_stage, m_fail, m_open, m_lock, exp_sdrd, exp_oe);
  endtask

  task automatic key_seq_model(string name);
    bus_cycle(1, 0, 1, 14'h1050); check_model(name);
    bus_cycle(1, 0, 1, 14'h10A0); check_model(name);
    bus_cycle(1, 0, 1, 14'h1090); check_model(name);
    bus_cycle(1, 0, 1, 14'h10C0); check_model(name);
  endtask

  typedef struct {
    string       name;
    bit          v, sn, rw;
    logic [13:0] a;
    int          e_stage, e_fail;
    bit          e_unl, e_lock, e_sdrd, e_oe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string n, bit v, bit sn, bit rw, logic [13:0] a,
                     int es, int ef, bit eu, bit el, bit ed, bit eo);
    vec_t t;
    t.name = n; t.v = v; t.sn = sn; t.rw = rw; t.a = a;
    t.e_stage = es; t.e_fail = ef; t.e_unl = eu; t.e_lock = el; t.e_sdrd = ed; t.e_oe = eo;
    vecs.push_back(t);
  endtask

  initial begin
    int lock_cycles, guard, r, f;
    bit port;
    logic [13:0] a;

    // Directed vectors from reset: unlock, stream, relock, partial miss, ignored cycles.
    add("key_s1",     1,0,1, 14'h1050, 1,0,0,0,0,0);
    add("key_s2",     1,0,1, 14'h10A0, 2,0,0,0,0,0);
    add("key_s3",     1,0,1, 14'h1090, 3,0,0,0,0,0);
    add("key_s4",     1,0,1, 14'h10C0, 4,0,1,0,0,0);
    add("dat_0",      1,0,1, 14'h1100, 4,0,1,0,1,1);
    add("idle",       0,0,1, 14'h1100, 4,0,1,0,0,0);
    add("dat_1",      1,0,1, 14'h1100, 4,0,1,0,0,1);
    add("dat_2",      1,0,1, 14'h1100, 4,0,1,0,0,1);
    add("relock_5",   1,0,1, 14'h1050, 1,0,0,0,0,0);
    add("rk_s2",      1,0,1, 14'h10A0, 2,0,0,0,0,0);
    add("miss_3",     1,0,1, 14'h1030, 0,1,0,0,0,0);
    add("miss_then5", 1,0,1, 14'h1050, 1,1,0,0,0,0);
    add("decoy_dat",  1,0,1, 14'h1100, 1,1,0,0,1,1);
    add("write_ign",  1,0,0, 14'h1050, 1,1,0,0,0,0);
    add("desel_ign",  1,1,1, 14'h1050, 1,1,0,0,0,0);
    add("window_ign", 1,0,1, 14'h3050, 1,1,0,0,0,0);
    add("win_dat_ign",1,0,1, 14'h3100, 1,1,0,0,0,0);
    add("re_s2",      1,0,1, 14'h10A0, 2,1,0,0,0,0);
    add("re_s3",      1,0,1, 14'h1090, 3,1,0,0,0,0);
    add("re_s4",      1,0,1, 14'h10C0, 4,0,1,0,0,0);
    add("re_dat_0",   1,0,1, 14'h1100, 4,0,1,0,1,1);
    add("re_dat_1",   1,0,1, 14'h1100, 4,0,1,0,0,1);

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus_cycle(vecs[i].v, vecs[i].sn, vecs[i].rw, vecs[i].a);
      check(vecs[i].name, vecs[i].e_stage, vecs[i].e_fail, vecs[i].e_unl,
            vecs[i].e_lock, vecs[i].e_sdrd, vecs[i].e_oe);
    end

    // Three wrong keys from OPEN: the first is a relock miss, the third trips lockout.
    bus_cycle(1, 0, 1, 14'h1000); check("wrong_1", 0, 1, 0, 0, 0, 0);
    bus_cycle(1, 0, 1, 14'h1000); check("wrong_2", 0, 2, 0, 0, 0, 0);
    bus_cycle(1, 0, 1, 14'h1000); check("wrong_3", 0, 0, 0, 1, 0, 0);
    lock_cycles = 1;
    bus_cycle(1, 0, 1, 14'h1050); check("lock_key_ign", 0, 0, 0, 1, 0, 0);
    if (locked_out) lock_cycles++;
    bus_cycle(1, 0, 1, 14'h1100); check("lock_dat", 0, 0, 0, 1, 0, 1);
    if (locked_out) lock_cycles++;
    guard = 0;
    while (locked_out === 1'b1 && guard < 2000) begin
      bus_cycle(0, 1, 0, 14'h0000);
      check_model("lock_wait");
      if (locked_out) lock_cycles++;
      guard++;
    end
    n_checks++;
    if (lock_cycles != 1024) begin
      n_errors++;
      $display("FAIL lock_len: got %0d locked cycles, expected 1024", lock_cycles);
    end
    key_seq_model("post_lock_key");
    bus_cycle(1, 0, 1, 14'h1100); check("post_lock_dat", 4, 0, 1, 0, 1, 1);

    // Asynchronous reset mid-sequence must clear immediately, without a clock edge.
    bus_cycle(1, 0, 1, 14'h1050); check_model("pre_rst_s1");
    bus_cycle(1, 0, 1, 14'h10A0); check("pre_rst_s2", 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    key_seq_model("after_rst_key");
    bus_cycle(1, 0, 1, 14'h1100); check("after_rst_dat", 4, 0, 1, 0, 1, 1);

    // Randomized traffic biased toward the expected next key step.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      f = (r < 60) ? key_steps[(m_stage < 4) ? m_stage : 0] : $urandom_range(0, 15);
      port = ($urandom_range(0, 3) == 0);
      a = {2'b01, 3'($urandom), port, 4'(f), 4'($urandom)};
      if ($urandom_range(0, 9) == 0) a[13] = 1'b1;
      bus_cycle($urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) != 0, a);
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
